// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
// Module      : btb_predictor
// Description : 8-entry (by default) fully associative branch target buffer
//               with 2-bit saturating direction counters.
//               IF side performs a combinational lookup; EX side compares the
//               resolved outcome against the prediction carried down the pipe,
//               raises a flush request and trains the table on the next edge.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst              clock (rising edge), synchronous active-high reset
//   lk_pc_i               IF-stage PC to look up
//   lk_hit_o              tag match on a valid entry
//   lk_hitpos_o           index of the matching entry (0 on miss)
//   lk_pcpre_o            predicted next PC
//   rs_valid_i            EX holds a branch/jump
//   rs_pc_i, rs_taken_i,  resolved branch PC, direction and taken target
//   rs_target_i
//   rs_pcpre_i, rs_hit_i, prediction information carried from IF
//   rs_hitpos_i
//   mispredict_o          flush request (combinational)
//   redirect_pc_o         correct next PC (combinational)
//   stat_br_o, stat_mp_o  resolved-branch / mispredict counters
// Configuration
//   BTB_STATS_EN          when defined, builds the statistics counters;
//                         otherwise stat_br_o = stat_mp_o = 0.
// ============================================================================
module btb_predictor #(
    parameter int         IDX_W    = 3,
    parameter int         PC_W     = 32,
    parameter logic [1:0] CNT_INIT = 2'd2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  lk_pc_i,
    output logic             lk_hit_o,
    output logic [IDX_W-1:0] lk_hitpos_o,
    output logic [PC_W-1:0]  lk_pcpre_o,
    input  logic             rs_valid_i,
    input  logic [PC_W-1:0]  rs_pc_i,
    input  logic             rs_taken_i,
    input  logic [PC_W-1:0]  rs_target_i,
    input  logic [PC_W-1:0]  rs_pcpre_i,
    input  logic             rs_hit_i,
    input  logic [IDX_W-1:0] rs_hitpos_i,
    output logic             mispredict_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic [31:0]      stat_br_o,
    output logic [31:0]      stat_mp_o
);

    localparam int              c_ENTRIES = 1 << IDX_W;
    localparam logic [PC_W-1:0] c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Table storage. Tags and targets are qualified by valid, so only
    // valid/cnt/rr need a reset.
    // ------------------------------------------------------------------
    logic             r_valid  [c_ENTRIES];
    logic [PC_W-1:0]  r_tag    [c_ENTRIES];
    logic [PC_W-1:0]  r_target [c_ENTRIES];
    logic [1:0]       r_cnt    [c_ENTRIES];
    logic [IDX_W-1:0] r_rr;

    // ------------------------------------------------------------------
    // IF lookup. Scanning from the top down lets the lowest matching
    // index win should duplicate tags ever exist.
    // ------------------------------------------------------------------
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_lk_pos;
    logic [PC_W-1:0]  w_lk_tgt;
    logic [1:0]       w_lk_cnt;

    always_comb begin
        w_lk_hit = 1'b0;
        w_lk_pos = '0;
        w_lk_tgt = '0;
        w_lk_cnt = 2'd0;
        for (int i = c_ENTRIES - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_tag[i] == lk_pc_i)) begin
                w_lk_hit = 1'b1;
                w_lk_pos = IDX_W'(i);
                w_lk_tgt = r_target[i];
                w_lk_cnt = r_cnt[i];
            end
        end
    end

    assign lk_hit_o    = w_lk_hit;
    assign lk_hitpos_o = w_lk_pos;
    // Counter values 2 and 3 predict taken (MSB of the counter).
    assign lk_pcpre_o  = (w_lk_hit && w_lk_cnt[1]) ? w_lk_tgt : (lk_pc_i + c_PC_ONE);

    // ------------------------------------------------------------------
    // EX resolve
    // ------------------------------------------------------------------
    logic [PC_W-1:0] w_act_pc;
    logic            w_mispredict;

    assign w_act_pc      = rs_taken_i ? rs_target_i : (rs_pc_i + c_PC_ONE);
    assign w_mispredict  = rs_valid_i && (w_act_pc != rs_pcpre_i);
    assign mispredict_o  = w_mispredict;
    assign redirect_pc_o = w_act_pc;

    // ------------------------------------------------------------------
    // Update decision. The carried hit is re-qualified against the current
    // entry so that an entry replaced while the branch was in flight is
    // treated as a miss instead of training the wrong branch.
    // ------------------------------------------------------------------
    logic             w_eff_hit;
    logic             w_has_free;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_alloc_idx;

    assign w_eff_hit = rs_hit_i && r_valid[rs_hitpos_i] && (r_tag[rs_hitpos_i] == rs_pc_i);

    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = c_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    assign w_alloc_idx = w_has_free ? w_free_idx : r_rr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= 2'd0;
            end
            r_rr <= '0;
        end else if (rs_valid_i) begin
            if (w_eff_hit) begin
                if (rs_taken_i) begin
                    if (r_cnt[rs_hitpos_i] != 2'd3) begin
                        r_cnt[rs_hitpos_i] <= r_cnt[rs_hitpos_i] + 2'd1;
                    end
                    r_target[rs_hitpos_i] <= rs_target_i;
                end else if (r_cnt[rs_hitpos_i] != 2'd0) begin
                    r_cnt[rs_hitpos_i] <= r_cnt[rs_hitpos_i] - 2'd1;
                end
            end else if (rs_taken_i) begin
                r_valid[w_alloc_idx]  <= 1'b1;
                r_tag[w_alloc_idx]    <= rs_pc_i;
                r_target[w_alloc_idx] <= rs_target_i;
                r_cnt[w_alloc_idx]    <= CNT_INIT;
                // Round-robin only moves when a live entry is evicted.
                if (!w_has_free) begin
                    r_rr <= r_rr + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef BTB_STATS_EN
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br <= 32'd0;
            r_stat_mp <= 32'd0;
        end else begin
            if (rs_valid_i) begin
                r_stat_br <= r_stat_br + 32'd1;
            end
            if (w_mispredict) begin
                r_stat_mp <= r_stat_mp + 32'd1;
            end
        end
    end

    assign stat_br_o = r_stat_br;
    assign stat_mp_o = r_stat_mp;
`else
    assign stat_br_o = 32'd0;
    assign stat_mp_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_btb_predictor
// Description : Self-checking bench for btb_predictor. A behavioural model of
//               the branch target buffer (plain arrays) is compared with the
//               DUT on every falling edge; directed scenarios add literal
//               expectations, followed by a randomized phase.
// Revision    : 1.0  initial release
// ============================================================================
module tb_btb_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic [2:0]  lk_hitpos;
    logic [31:0] lk_pcpre;
    logic        rs_valid;
    logic [31:0] rs_pc;
    logic        rs_taken;
    logic [31:0] rs_target;
    logic [31:0] rs_pcpre;
    logic        rs_hit;
    logic [2:0]  rs_hitpos;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] stat_br;
    logic [31:0] stat_mp;

    btb_predictor dut (
        .clk          (clk),
        .rst          (rst),
        .lk_pc_i      (lk_pc),
        .lk_hit_o     (lk_hit),
        .lk_hitpos_o  (lk_hitpos),
        .lk_pcpre_o   (lk_pcpre),
        .rs_valid_i   (rs_valid),
        .rs_pc_i      (rs_pc),
        .rs_taken_i   (rs_taken),
        .rs_target_i  (rs_target),
        .rs_pcpre_i   (rs_pcpre),
        .rs_hit_i     (rs_hit),
        .rs_hitpos_i  (rs_hitpos),
        .mispredict_o (mispredict),
        .redirect_pc_o(redirect_pc),
        .stat_br_o    (stat_br),
        .stat_mp_o    (stat_mp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // ---------------- behavioural model ----------------
    bit          m_valid [8];
    logic [31:0] m_tag   [8];
    logic [31:0] m_tgt   [8];
    int          m_cnt   [8];
    int          m_rr;
    logic [31:0] m_br;
    logic [31:0] m_mp;

    function automatic void m_lookup(input logic [31:0] pc, output bit hit,
                                     output logic [2:0] pos, output logic [31:0] pre);
        hit = 1'b0;
        pos = 3'd0;
        pre = pc + 32'd1;
        for (int i = 0; i < 8; i++) begin
            if (!hit && m_valid[i] && m_tag[i] == pc) begin
                hit = 1'b1;
                pos = 3'(i);
                if (m_cnt[i] >= 2) pre = m_tgt[i];
            end
        end
    endfunction

    function automatic logic [31:0] m_actual();
        return rs_taken ? rs_target : rs_pc + 32'd1;
    endfunction

    function automatic bit m_mispred();
        return rs_valid && (m_actual() != rs_pcpre);
    endfunction

    // Applies the effect of the coming rising edge given the current inputs.
    task automatic m_update();
        int slot;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = 0;
            end
            m_rr = 0;
            m_br = 0;
            m_mp = 0;
            return;
        end
        if (m_mispred()) m_mp = m_mp + 1;
        if (!rs_valid) return;
        m_br = m_br + 1;
        if (rs_hit && m_valid[rs_hitpos] && m_tag[rs_hitpos] == rs_pc) begin
            if (rs_taken) begin
                m_cnt[rs_hitpos] = (m_cnt[rs_hitpos] == 3) ? 3 : m_cnt[rs_hitpos] + 1;
                m_tgt[rs_hitpos] = rs_target;
            end else begin
                m_cnt[rs_hitpos] = (m_cnt[rs_hitpos] == 0) ? 0 : m_cnt[rs_hitpos] - 1;
            end
        end else if (rs_taken) begin
            slot = -1;
            for (int i = 7; i >= 0; i--) if (!m_valid[i]) slot = i;
            if (slot < 0) begin
                slot = m_rr;
                m_rr = (m_rr + 1) % 8;
            end
            m_valid[slot] = 1'b1;
            m_tag[slot]   = rs_pc;
            m_tgt[slot]   = rs_target;
            m_cnt[slot]   = 2;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        bit          e_hit;
        logic [2:0]  e_pos;
        logic [31:0] e_pre;
        if (chk_en) begin
            m_lookup(lk_pc, e_hit, e_pos, e_pre);
            chk("lk_hit", 32'(lk_hit), 32'(e_hit));
            chk("lk_hitpos", 32'(lk_hitpos), 32'(e_pos));
            chk("lk_pcpre", lk_pcpre, e_pre);
            chk("mispredict", 32'(mispredict), 32'(m_mispred()));
            chk("redirect_pc", redirect_pc, m_actual());
`ifdef BTB_STATS_EN
            chk("stat_br", stat_br, m_br);
            chk("stat_mp", stat_mp, m_mp);
`else
            chk("stat_br", stat_br, 32'd0);
            chk("stat_mp", stat_mp, 32'd0);
`endif
        end
    end

    // ---------------- driver helpers ----------------
    task automatic to_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic commit();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        to_neg();
        commit();
    endtask

    task automatic idle_rs();
        rs_valid = 1'b0; rs_pc = 32'd0; rs_taken = 1'b0; rs_target = 32'd0;
        rs_pcpre = 32'd0; rs_hit = 1'b0; rs_hitpos = 3'd0;
    endtask

    task automatic resolve(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                           input logic [31:0] pre, input bit hit, input logic [2:0] pos);
        rs_valid = 1'b1; rs_pc = pc; rs_taken = tk; rs_target = tgt;
        rs_pcpre = pre; rs_hit = hit; rs_hitpos = pos;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Lookup check with literal expectations.
    task automatic look(input string name, input logic [31:0] pc, input bit hit,
                        input logic [2:0] pos, input logic [31:0] pre);
        lk_pc = pc;
        to_neg();
        chk({name, "_hit"}, 32'(lk_hit), 32'(hit));
        chk({name, "_pos"}, 32'(lk_hitpos), 32'(pos));
        chk({name, "_pre"}, lk_pcpre, pre);
        commit();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          e_hit;
        logic [2:0]  e_pos;
        logic [31:0] e_pre;
        rst = 1'b1;
        lk_pc = 32'h10;
        idle_rs();
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset();

        // Reset state lookup.
        look("rst_look", 32'h10, 1'b0, 3'd0, 32'h11);

        // First taken resolve allocates entry 0.
        resolve(32'h10, 1'b1, 32'h40, 32'h11, 1'b0, 3'd0);
        to_neg();
        chk("first_mp", 32'(mispredict), 32'd1);
        chk("first_redir", redirect_pc, 32'h40);
        commit();
        idle_rs();
        look("alloc_look", 32'h10, 1'b1, 3'd0, 32'h40);

        // Not taken twice: cnt 2->1->0.
        resolve(32'h10, 1'b0, 32'h40, 32'h40, 1'b1, 3'd0);
        to_neg();
        chk("nt1_mp", 32'(mispredict), 32'd1);
        chk("nt1_redir", redirect_pc, 32'h11);
        commit();
        idle_rs();
        look("nt1_look", 32'h10, 1'b1, 3'd0, 32'h11);
        resolve(32'h10, 1'b0, 32'h40, 32'h11, 1'b1, 3'd0);
        to_neg();
        chk("nt2_mp", 32'(mispredict), 32'd0);
        commit();
        idle_rs();
        look("nt2_look", 32'h10, 1'b1, 3'd0, 32'h11);

        // Fill all entries, then force one round-robin replacement.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            resolve(32'h100 + 32'(k), 1'b1, 32'h200 + 32'(k), 32'h101 + 32'(k), 1'b0, 3'd0);
            cyc();
        end
        idle_rs();
        look("evict_miss", 32'h100, 1'b0, 3'd0, 32'h101);
        look("evict_new", 32'h108, 1'b1, 3'd0, 32'h208);
        look("keep1", 32'h101, 1'b1, 3'd1, 32'h201);
        // rr must now be 1: the next new branch replaces index 1.
        resolve(32'h109, 1'b1, 32'h209, 32'h10a, 1'b0, 3'd0);
        cyc();
        idle_rs();
        look("rr1_gone", 32'h101, 1'b0, 3'd0, 32'h102);
        look("rr1_new", 32'h109, 1'b1, 3'd1, 32'h209);

        // Stale hit: entry 0 now holds 0x108, so this is a miss and allocates at rr=2.
        resolve(32'h100, 1'b1, 32'h300, 32'h101, 1'b1, 3'd0);
        cyc();
        idle_rs();
        look("stale_alloc", 32'h100, 1'b1, 3'd2, 32'h300);
        look("stale_keep", 32'h108, 1'b1, 3'd0, 32'h208);
        // Entry 0 count still 2: one not-taken drops it to weak not-taken.
        resolve(32'h108, 1'b0, 32'h208, 32'h208, 1'b1, 3'd0);
        cyc();
        idle_rs();
        look("stale_cnt", 32'h108, 1'b1, 3'd0, 32'h109);

        // Reset wins over a simultaneous taken resolve.
        rst = 1'b1;
        resolve(32'h500, 1'b1, 32'h600, 32'h501, 1'b0, 3'd0);
        cyc();
        rst = 1'b0;
        idle_rs();
        lk_pc = 32'h500;
        to_neg();
        chk("rst_upd_hit", 32'(lk_hit), 32'd0);
        chk("rst_upd_stat", stat_br, 32'd0);
        commit();
        look("rst_upd_old", 32'h108, 1'b0, 3'd0, 32'h109);

        // Randomized phase: small PC pool (12 > 8 entries) forces replacement.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            rst = ($urandom_range(0, 199) == 0);
            lk_pc = 32'h20 + 32'($urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) lk_pc = 32'hffff_ffff;
            pc = 32'h20 + 32'($urandom_range(0, 11));
            rs_valid  = ($urandom_range(0, 3) != 0);
            rs_pc     = pc;
            rs_taken  = $urandom_range(0, 1) == 1;
            rs_target = 32'h80 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7) begin
                m_lookup(pc, e_hit, e_pos, e_pre);
                rs_hit = e_hit; rs_hitpos = e_pos; rs_pcpre = e_pre;
            end else begin
                rs_hit    = $urandom_range(0, 1) == 1;
                rs_hitpos = 3'($urandom_range(0, 7));
                rs_pcpre  = 32'h80 + 32'($urandom_range(0, 3));
            end
            cyc();
        end
        rst = 1'b0;
        idle_rs();
        cyc();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
